// File: rtl/emg_request_arbiter.sv
// Emergency-vehicle request arbiter: round-robin over N/E/S/W requests, with an all-red clearance before each grant and min/max grant hold.
// Optional EMG_SAME_AXIS_SKIP_EN: skip clearance when the next winner shares the axis of a grant that ended one cycle earlier.
module emg_request_arbiter #(
    parameter int unsigned CNT_W     = 24,
    parameter int unsigned CLEAR_CYC = 1000000,
    parameter int unsigned MIN_HOLD  = 2000000,
    parameter int unsigned MAX_HOLD  = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic       emergency,
    output logic [1:0] emg_dir,
    output logic       all_red,
    output logic [3:0] grant,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        GRANT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_HOLD - 1);
    localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0]       req_q;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [1:0]       win_dir_q, win_dir_d;
    logic             timeout_d;

    logic             emergency_q, all_red_q, timeout_q;
    logic [1:0]       emg_dir_q;
    logic [3:0]       grant_q;

    logic             win_found;
    logic [1:0]       win_idx;
    logic [1:0]       cand;
    logic             skip_clear;

`ifdef EMG_SAME_AXIS_SKIP_EN
    logic             just_ended_q, just_ended_d;
    logic             last_axis_q;

    assign skip_clear = just_ended_q && (win_idx[0] == last_axis_q);
`else
    assign skip_clear = 1'b0;
`endif

    // Round-robin search starting at rr_ptr_q, wrapping mod 4.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = rr_ptr_q + 2'(i);
            if (!win_found && req_q[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 1'b1;
        win_dir_d = win_dir_q;
        rr_ptr_d  = rr_ptr_q;
        timeout_d = 1'b0;
`ifdef EMG_SAME_AXIS_SKIP_EN
        just_ended_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (win_found) begin
                    win_dir_d = win_idx;
                    state_d   = skip_clear ? GRANT : CLEAR;
                end
            end
            CLEAR: begin
                if (!req_q[win_dir_q]) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == CLEAR_LAST) begin
                    state_d = GRANT;
                    timer_d = '0;
                end
            end
            GRANT: begin
                // MAX_HOLD wins when both exit conditions coincide, so timeout still pulses.
                if ((timer_q == MAX_LAST) || ((timer_q >= MIN_LAST) && !req_q[win_dir_q])) begin
                    state_d   = IDLE;
                    timer_d   = '0;
                    rr_ptr_d  = win_dir_q + 2'd1;
                    timeout_d = (timer_q == MAX_LAST);
`ifdef EMG_SAME_AXIS_SKIP_EN
                    just_ended_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            req_q       <= '0;
            rr_ptr_q    <= '0;
            win_dir_q   <= '0;
            emergency_q <= 1'b0;
            all_red_q   <= 1'b0;
            emg_dir_q   <= '0;
            grant_q     <= '0;
            timeout_q   <= 1'b0;
`ifdef EMG_SAME_AXIS_SKIP_EN
            just_ended_q <= 1'b0;
            last_axis_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            req_q       <= req;
            rr_ptr_q    <= rr_ptr_d;
            win_dir_q   <= win_dir_d;
            emergency_q <= (state_d == GRANT);
            all_red_q   <= (state_d == CLEAR);
            emg_dir_q   <= (state_d == GRANT) ? win_dir_d : 2'd0;
            grant_q     <= (state_d == GRANT) ? (4'b0001 << win_dir_d) : 4'b0000;
            timeout_q   <= timeout_d;
`ifdef EMG_SAME_AXIS_SKIP_EN
            just_ended_q <= just_ended_d;
            if (just_ended_d) begin
                last_axis_q <= win_dir_q[0];
            end
`endif
        end
    end

    assign emergency = emergency_q;
    assign all_red   = all_red_q;
    assign emg_dir   = emg_dir_q;
    assign grant     = grant_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_emg_request_arbiter.sv
// Scoreboard bench for emg_request_arbiter: directed request patterns push expected grants; a negedge monitor assembles observed grants and compares.
`timescale 1ns/1ps
module tb_emg_request_arbiter;

    localparam int CLR  = 4;
    localparam int MINH = 8;
    localparam int MAXH = 20;
`ifdef EMG_SAME_AXIS_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       emergency;
    logic [1:0] emg_dir;
    logic       all_red;
    logic [3:0] grant;
    logic       timeout;

    emg_request_arbiter #(
        .CNT_W     (8),
        .CLEAR_CYC (CLR),
        .MIN_HOLD  (MINH),
        .MAX_HOLD  (MAXH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .emergency (emergency),
        .emg_dir   (emg_dir),
        .all_red   (all_red),
        .grant     (grant),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] dir;
        int         len;
        logic       to;
        int         pre;
        int         gap;
        int         start;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ar_total = 0;
    int   g_starts = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: assembles each observed grant and compares it against the scoreboard head.
    bit         in_g = 1'b0;
    logic [1:0] cur_dir;
    int         cur_len, cur_pre, cur_gap, cur_start;
    int         gap = -1;
    int         clr_run = 0;
    exp_t       e;

    always @(negedge clk) begin
        if (reset) begin
            in_g    = 1'b0;
            gap     = -1;
            clr_run = 0;
        end else if (emergency) begin
            check("grant_onehot", int'(grant), int'(4'b0001 << emg_dir));
            check("grant_allred", int'(all_red), 0);
            check("grant_timeout", int'(timeout), 0);
            if (!in_g) begin
                in_g      = 1'b1;
                cur_dir   = emg_dir;
                cur_len   = 0;
                cur_pre   = clr_run;
                cur_gap   = gap;
                cur_start = cyc;
                g_starts++;
            end else begin
                check("grant_dir_stable", int'(emg_dir), int'(cur_dir));
            end
            cur_len++;
        end else begin
            check("idle_grant_dir_zero", int'({grant, emg_dir}), 0);
            if (in_g) begin
                in_g = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got dir %0d len %0d, expected no grant", cur_dir, cur_len);
                end else begin
                    e = sb.pop_front();
                    check("sb_dir", int'(cur_dir), int'(e.dir));
                    check("sb_len", cur_len, e.len);
                    check("sb_timeout", int'(timeout), int'(e.to));
                    check("sb_clear_cycles", cur_pre, e.pre);
                    if (e.gap >= 0) check("sb_gap", cur_gap, e.gap);
                    if (e.start >= 0) check("sb_start", cur_start, e.start);
                end
                gap = 0;
            end else begin
                check("idle_timeout", int'(timeout), 0);
            end
            if (gap >= 0) gap++;
            if (all_red) begin
                clr_run++;
                ar_total++;
            end else begin
                clr_run = 0;
            end
        end
    end

    task automatic push(input logic [1:0] d, input int len, input logic to, input int pre, input int gp, input int st);
        exp_t x;
        x.dir = d; x.len = len; x.to = to; x.pre = pre; x.gap = gp; x.start = st;
        sb.push_back(x);
    endtask

    task automatic outputs_zero(input string name);
        check(name, int'({emergency, emg_dir, all_red, grant, timeout}), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        req = 4'b0000;
        #1 outputs_zero("reset_outputs");
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic wait_sb(input int n, input int budget, input string name);
        int k = 0;
        while (sb.size() > n && k < budget) begin
            @(negedge clk);
            #1 k++;
        end
        check(name, int'(sb.size() > n), 0);
        if (sb.size() > n) sb.delete();
    endtask

    task automatic wait_em(input logic [1:0] d, input int budget, input string name);
        int k = 0;
        while (!(emergency && emg_dir == d) && k < budget) begin
            @(negedge clk);
            #1 k++;
        end
        check(name, int'(emergency && emg_dir == d), 1);
    endtask

    int t0, a0, gs0;

    initial begin
        do_reset();

        // Single N request: CLEAR 4 cycles, grant held to MIN_HOLD after request drops.
        @(posedge clk);
        #1 req = 4'b0001;
        t0 = cyc;
        push(2'd0, MINH, 1'b0, CLR, -1, t0 + 6);
        repeat (10) @(posedge clk);
        #1 req = 4'b0000;
        wait_sb(0, 100, "t1_wait");
        repeat (5) @(negedge clk);

        // E held forever: MAX_HOLD timeout, E re-wins with no competitor.
        do_reset();
        @(posedge clk);
        #1 req = 4'b0010;
        push(2'd1, MAXH, 1'b1, CLR, -1, -1);
        push(2'd1, MAXH, 1'b1, SKIP ? 0 : CLR, SKIP ? 1 : CLR + 1, -1);
        if (SKIP) push(2'd1, MINH, 1'b0, 0, 1, -1);
        wait_sb(SKIP ? 1 : 0, 200, "t2_wait");
        @(posedge clk);
        #1 req = 4'b0000;
        wait_sb(0, 100, "t2_drain");
        repeat (10) @(negedge clk);

        // All four requesting: rotation N, E, S, W, N with timeouts.
        do_reset();
        @(posedge clk);
        #1 req = 4'b1111;
        push(2'd0, MAXH, 1'b1, CLR, -1, -1);
        for (int i = 1; i < 5; i++) push(2'(i), MAXH, 1'b1, CLR, CLR + 1, -1);
        wait_sb(0, 400, "t3_wait");
        @(posedge clk);
        #1 req = 4'b0000;
        repeat (10) @(negedge clk);

        // Short S request aborts CLEAR; rr pointer stays at N.
        do_reset();
        a0  = ar_total;
        gs0 = g_starts;
        @(posedge clk);
        #1 req = 4'b0100;
        repeat (3) @(posedge clk);
        #1 req = 4'b0000;
        repeat (8) @(negedge clk);
        check("abort_allred_cycles", ar_total - a0, 3);
        check("abort_no_grant", g_starts - gs0, 0);
        push(2'd0, MINH, 1'b0, CLR, -1, -1);
        @(posedge clk);
        #1 req = 4'b0101;
        wait_em(2'd0, 50, "t4_wait_grant");
        @(posedge clk);
        #1 req = 4'b0000;
        wait_sb(0, 100, "t4_drain");
        repeat (5) @(negedge clk);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        @(posedge clk);
        #1 req = 4'b1000;
        wait_em(2'd3, 50, "t5_wait_grant");
        repeat (3) @(negedge clk);
        check("t5_emergency_before_reset", int'(emergency), 1);
        #2 reset = 1'b1;
        req = 4'b0000;
        #1 outputs_zero("reset_mid_grant");
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1 outputs_zero("post_reset_idle");
        end

        // N drops as S rises: clearance skipped only with the same-axis option.
        do_reset();
        @(posedge clk);
        #1 req = 4'b0001;
        t0 = cyc;
        push(2'd0, MINH, 1'b0, CLR, -1, t0 + 6);
        push(2'd2, MINH, 1'b0, SKIP ? 0 : CLR, SKIP ? 1 : CLR + 1, -1);
        repeat (10) @(posedge clk);
        #1 req = 4'b0100;
        wait_em(2'd2, 60, "t6_wait_s");
        @(posedge clk);
        #1 req = 4'b0000;
        wait_sb(0, 100, "t6_drain");
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
